uart_tx_ctl: RTL and testbench
==============================

// Module: uart_tx_ctl
// PURPOSE
//   UART transmit serializer feeding the normal-path txd_tx input of the
//   loopback controller. Accepts bytes over a valid/ready handshake and emits
//   8-bit frames (start, 8 data LSB first, optional parity, 1 or 2 stop bits)
//   at a fixed baud rate derived from the clk_tx clock.
// PARAMETERS
//   CLOCK_RATE  50_000_000  clk_tx frequency in Hz
//   BAUD_RATE   115_200     serial bit rate in bits/s
//   PARITY      0           0 = none, 1 = odd, 2 = even
//   STOP_BITS   1           stop bits per frame, 1 or 2
//   (local) DIVISOR = (CLOCK_RATE + BAUD_RATE/2) / BAUD_RATE, clocks per bit
//           (434 at defaults); must be >= 2, else elaboration error
// PORTS
//   clk_tx      in   1  transmit clock
//   rst_clk_tx  in   1  active-high reset, synchronous to clk_tx
//   tx_data     in   8  byte to send, sampled on accept
//   tx_valid    in   1  tx_data valid
//   tx_ready    out  1  block can accept a byte this cycle
//   tx_busy     out  1  frame in progress (any state but IDLE)
//   txd_tx      out  1  serial data, idle high, registered
// BEHAVIOUR
//   - Reset: state IDLE, txd_tx = 1, tx_ready = 1, tx_busy = 0,
//     baud counter = 0, bit index = 0. Reset mid-frame aborts the frame;
//     txd_tx returns high on the cycle after reset is sampled.
//   - tx_ready = (state == IDLE), combinational from state. Accept occurs on
//     a clock edge with tx_valid & tx_ready; tx_data is latched into shift reg.
//   - tx_valid while busy is ignored; the byte is held by upstream, no drop.
//   - FSM: IDLE -> START -> DATA (8 bits) -> PARITY (if PARITY != 0)
//     -> STOP (STOP_BITS bits) -> IDLE.
//   - Each bit holds txd_tx for exactly DIVISOR clk_tx cycles; the baud
//     counter counts 0..DIVISOR-1 and the state or bit advances on terminal
//     count. The counter restarts at 0 on accept.
//   - txd_tx = 0 from the cycle after accept (START), then data bits
//     tx_data[0]..[7], then parity bit, then 1 for each stop bit.
//   - Parity: odd -> ^data ^ 1; even -> ^data, over the latched byte.
//   - Frame length F = (1 + 8 + (PARITY!=0) + STOP_BITS) * DIVISOR cycles.
//     On the last stop-bit terminal count the state returns to IDLE. The next
//     accept is possible on the first IDLE cycle, so back-to-back frames have
//     exactly 1 extra idle-high cycle: accept-to-accept = F + 1.
//   - Invalid PARITY (3) is treated as none; STOP_BITS other than 2 is
//     treated as 1.
//   - No output glitches: txd_tx comes straight from a flop.
// TESTING (CLOCK_RATE=1_000_000, BAUD_RATE=250_000 -> DIVISOR=4)
//   1 Reset release, no valid -> txd_tx=1, tx_ready=1, tx_busy=0 for 100 cyc.
//   2 Send 0xA5, PARITY=0, STOP_BITS=1 -> txd_tx bits 0,1,0,1,0,0,1,0,1,1
//     each 4 cycles, starting 1 cycle after accept; tx_ready low 40 cycles.
//   3 Hold tx_valid with 0x55 then 0x0F -> second accept exactly 41 cycles
//     after first; first tx_data change while busy has no effect on frame 1.
//   4 PARITY=1 with 0x03 -> parity bit 1; PARITY=2 with 0x03 -> parity 0;
//     STOP_BITS=2 -> 2 stop bits, accept-to-accept = 49 (PARITY!=0) cycles.
//   5 Assert rst_clk_tx during data bit 3 -> next cycle txd_tx=1, tx_ready=1;
//     a new byte sent afterwards produces a clean full frame.
//   6 Serial-checker receiver on txd_tx with 256 random bytes, random
//     tx_valid gaps -> all bytes received in order, no framing errors.

Source files
------------

// File: rtl/uart_tx_ctl.sv
// UART transmit serializer: accepts a byte on a valid/ready handshake and shifts out
// a start bit, 8 data bits (LSB first), optional parity and 1 or 2 stop bits.
module uart_tx_ctl #(
    parameter int CLOCK_RATE = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk_tx,
    input  logic       rst_clk_tx,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       txd_tx
);

    localparam int DIVISOR = (CLOCK_RATE + BAUD_RATE / 2) / BAUD_RATE;
    localparam int CNT_W   = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;

    localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(DIVISOR - 1);
    localparam bit               HAS_PARITY = (PARITY == 1) || (PARITY == 2);
    localparam bit               ODD_PARITY = (PARITY == 1);
    localparam logic [2:0]       STOP_LAST  = (STOP_BITS == 2) ? 3'd1 : 3'd0;

    generate
        if (DIVISOR < 2) begin : gDivisorCheck
            $error("uart_tx_ctl: DIVISOR must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic             txd_q, txd_d;
    logic             lastTick;

    assign lastTick = (baud_q == BAUD_LAST);

    always_ff @(posedge clk_tx) begin
        if (rst_clk_tx) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
        end
    end

    // Parity is fixed at accept time; the shift register drops one data bit per DATA terminal count.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        if (state_q == S_IDLE) begin
            baud_d = '0;
            bit_d  = '0;
            if (tx_valid) begin
                state_d = S_START;
                shift_d = tx_data;
                par_d   = (^tx_data) ^ ODD_PARITY;
            end
        end else begin
            baud_d = lastTick ? '0 : baud_q + CNT_W'(1);
            if (lastTick) begin
                case (state_q)
                    S_START: begin
                        state_d = S_DATA;
                        bit_d   = '0;
                    end
                    S_DATA: begin
                        if (bit_q == 3'd7) begin
                            state_d = HAS_PARITY ? S_PARITY : S_STOP;
                            bit_d   = '0;
                        end else begin
                            bit_d   = bit_q + 3'd1;
                            shift_d = {1'b0, shift_q[7:1]};
                        end
                    end
                    S_PARITY: begin
                        state_d = S_STOP;
                        bit_d   = '0;
                    end
                    S_STOP: begin
                        if (bit_q == STOP_LAST) begin
                            state_d = S_IDLE;
                            bit_d   = '0;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // The line level is chosen from the upcoming state so txd_tx itself is a plain flop output.
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
            S_PARITY: txd_d = par_q;
            default:  txd_d = 1'b1;
        endcase
    end

    assign tx_ready = (state_q == S_IDLE);
    assign tx_busy  = (state_q != S_IDLE);
    assign txd_tx   = txd_q;

endmodule

// File: tb/tb_uart_tx_ctl.sv
// Bench for uart_tx_ctl: three instances (no parity/1 stop, odd/1 stop, even/2 stop)
// with a per-cycle frame model and a mid-bit sampling serial receiver.
module tb_uart_tx_ctl;

    localparam int DIV     = 4;
    localparam int NRANDOM = 256;

    logic       clk;
    logic       rst     [3];
    logic [7:0] txData  [3];
    logic       txValid [3];
    logic       ready0, ready1, ready2;
    logic       busy0, busy1, busy2;
    logic       txd0, txd1, txd2;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] expQ[$];

    uart_tx_ctl #(.CLOCK_RATE(1_000_000), .BAUD_RATE(250_000), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk_tx(clk), .rst_clk_tx(rst[0]), .tx_data(txData[0]), .tx_valid(txValid[0]),
        .tx_ready(ready0), .tx_busy(busy0), .txd_tx(txd0));

    uart_tx_ctl #(.CLOCK_RATE(1_000_000), .BAUD_RATE(250_000), .PARITY(1), .STOP_BITS(1)) u_dut1 (
        .clk_tx(clk), .rst_clk_tx(rst[1]), .tx_data(txData[1]), .tx_valid(txValid[1]),
        .tx_ready(ready1), .tx_busy(busy1), .txd_tx(txd1));

    uart_tx_ctl #(.CLOCK_RATE(1_000_000), .BAUD_RATE(250_000), .PARITY(2), .STOP_BITS(2)) u_dut2 (
        .clk_tx(clk), .rst_clk_tx(rst[2]), .tx_data(txData[2]), .tx_valid(txValid[2]),
        .tx_ready(ready2), .tx_busy(busy2), .txd_tx(txd2));

    always #5 clk = ~clk;

    function automatic int cfgParity(int i);
        return i;
    endfunction

    function automatic int cfgStop(int i);
        return (i == 2) ? 2 : 1;
    endfunction

    function automatic logic getTxd(int i);
        case (i)
            0:       return txd0;
            1:       return txd1;
            default: return txd2;
        endcase
    endfunction

    function automatic logic getReady(int i);
        case (i)
            0:       return ready0;
            1:       return ready1;
            default: return ready2;
        endcase
    endfunction

    function automatic logic getBusy(int i);
        case (i)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic int numBits(int i);
        return 1 + 8 + ((cfgParity(i) != 0) ? 1 : 0) + cfgStop(i);
    endfunction

    // Reference line level for bit slot j of a frame carrying d.
    function automatic logic frameBit(int i, logic [7:0] d, int j);
        int ones;
        ones = $countones(d);
        if (j == 0) return 1'b0;
        if (j <= 8) return d[j-1];
        if (j == 9 && cfgParity(i) == 1) return (ones % 2 == 0) ? 1'b1 : 1'b0;
        if (j == 9 && cfgParity(i) == 2) return (ones % 2 == 1) ? 1'b1 : 1'b0;
        return 1'b1;
    endfunction

    // Called at the negedge before the accepting posedge; returns on the first idle negedge.
    task automatic expect_frame(input int i, input logic [7:0] d, input bit holdValid, input logic [7:0] nextData);
        int nb;
        logic expBit;
        nb = numBits(i);
        for (int k = 1; k <= nb * DIV; k++) begin
            @(negedge clk);
            expBit = frameBit(i, d, (k - 1) / DIV);
            checks++;
            if (getTxd(i) !== expBit || getReady(i) !== 1'b0 || getBusy(i) !== 1'b1) begin
                failures++;
                $display("[TB] FAIL frame dut%0d byte=%02h cyc=%0d: txd=%b ready=%b busy=%b, expected txd=%b ready=0 busy=1",
                         i, d, k, getTxd(i), getReady(i), getBusy(i), expBit);
            end
            if (k == 1) begin
                if (holdValid) txData[i] = nextData;
                else txValid[i] = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (getTxd(i) !== 1'b1 || getReady(i) !== 1'b1 || getBusy(i) !== 1'b0) begin
            failures++;
            $display("[TB] FAIL end-of-frame dut%0d: txd=%b ready=%b busy=%b, expected 1 1 0",
                     i, getTxd(i), getReady(i), getBusy(i));
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (getTxd(i) !== 1'b1 || getReady(i) !== 1'b1 || getBusy(i) !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL reset-idle dut%0d cyc=%0d: txd=%b ready=%b busy=%b, expected 1 1 0",
                             i, c, getTxd(i), getReady(i), getBusy(i));
                end
            end
        end
    endtask

    task automatic test_single_frame;
        txData[0]  = 8'hA5;
        txValid[0] = 1'b1;
        expect_frame(0, 8'hA5, 1'b0, 8'h00);
    endtask

    task automatic test_back_to_back;
        txData[0]  = 8'h55;
        txValid[0] = 1'b1;
        expect_frame(0, 8'h55, 1'b1, 8'h0F);
        expect_frame(0, 8'h0F, 1'b0, 8'h00);
    endtask

    task automatic test_parity_stop;
        txData[1]  = 8'h03;
        txValid[1] = 1'b1;
        expect_frame(1, 8'h03, 1'b0, 8'h00);
        txData[2]  = 8'h03;
        txValid[2] = 1'b1;
        expect_frame(2, 8'h03, 1'b1, 8'hC4);
        expect_frame(2, 8'hC4, 1'b0, 8'h00);
    endtask

    task automatic test_reset_mid_frame;
        logic expBit;
        txData[0]  = 8'hA5;
        txValid[0] = 1'b1;
        // Slot 4 of the frame is data bit 3; cycle 18 is inside it.
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 1) txValid[0] = 1'b0;
            expBit = frameBit(0, 8'hA5, (k - 1) / DIV);
            checks++;
            if (getTxd(0) !== expBit) begin
                failures++;
                $display("[TB] FAIL pre-abort cyc=%0d: txd=%b expected %b", k, getTxd(0), expBit);
            end
        end
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        checks++;
        if (getTxd(0) !== 1'b1 || getReady(0) !== 1'b1 || getBusy(0) !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort-reset: txd=%b ready=%b busy=%b, expected 1 1 0",
                     getTxd(0), getReady(0), getBusy(0));
        end
        txData[0]  = 8'h3C;
        txValid[0] = 1'b1;
        expect_frame(0, 8'h3C, 1'b0, 8'h00);
    endtask

    task automatic randomSender(input int i);
        logic [7:0] b;
        int w;
        for (int n = 0; n < NRANDOM; n++) begin
            repeat ($urandom_range(0, 6)) @(negedge clk);
            b          = 8'($urandom);
            txData[i]  = b;
            txValid[i] = 1'b1;
            w = 0;
            while (getReady(i) !== 1'b1 && w < 200) begin
                @(negedge clk);
                w++;
            end
            if (w >= 200) begin
                checks++;
                failures++;
                $display("[TB] FAIL sender-timeout dut%0d byte %0d: ready stayed %b, expected 1", i, n, getReady(i));
                txValid[i] = 1'b0;
                return;
            end
            expQ.push_back(b);
            @(negedge clk);
            txValid[i] = 1'b0;
        end
    endtask

    task automatic randomReceiver(input int i);
        int got = 0;
        int budget = 0;
        logic [7:0] b;
        logic [7:0] exp;
        logic pbit;
        bit frameOk;
        while (got < NRANDOM && budget < 40000) begin
            @(negedge clk);
            budget++;
            if (getTxd(i) === 1'b0) begin
                frameOk = 1'b1;
                pbit    = 1'b0;
                repeat (DIV / 2) @(negedge clk);
                if (getTxd(i) !== 1'b0) frameOk = 1'b0;
                for (int j = 0; j < 8; j++) begin
                    repeat (DIV) @(negedge clk);
                    b[j] = getTxd(i);
                end
                if (cfgParity(i) != 0) begin
                    repeat (DIV) @(negedge clk);
                    pbit = getTxd(i);
                    if (cfgParity(i) == 1 && ($countones({b, pbit}) % 2) != 1) frameOk = 1'b0;
                    if (cfgParity(i) == 2 && ($countones({b, pbit}) % 2) != 0) frameOk = 1'b0;
                end
                for (int s = 0; s < cfgStop(i); s++) begin
                    repeat (DIV) @(negedge clk);
                    if (getTxd(i) !== 1'b1) frameOk = 1'b0;
                end
                budget += numBits(i) * DIV;
                exp = (expQ.size() > 0) ? expQ.pop_front() : 8'hxx;
                checks++;
                if (b !== exp) begin
                    failures++;
                    $display("[TB] FAIL rx-data dut%0d #%0d: received %02h, expected %02h", i, got, b, exp);
                end
                checks++;
                if (!frameOk) begin
                    failures++;
                    $display("[TB] FAIL rx-framing dut%0d #%0d: byte %02h parity=%b bad framing, expected clean frame",
                             i, got, b, pbit);
                end
                got++;
            end
        end
        checks++;
        if (got != NRANDOM) begin
            failures++;
            $display("[TB] FAIL rx-count dut%0d: received %0d frames, expected %0d", i, got, NRANDOM);
        end
    endtask

    task automatic test_random_stream;
        for (int i = 0; i < 3; i++) begin
            expQ.delete();
            fork
                randomSender(i);
                randomReceiver(i);
            join
            repeat (DIV * 12) @(negedge clk);
        end
    endtask

    initial begin
        clk = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rst[i]     = 1'b1;
            txData[i]  = 8'h00;
            txValid[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_parity_stop();
        test_reset_mid_frame();
        test_random_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
